// File: rtl/ps2_mouse_ctrl_if.sv
// Signal bundle between the PS/2 mouse sequencer, the PS/2 transceiver and the stream FSM.
// The bench or a parent drives through master; the sequencer uses slave.
interface ps2_mouse_ctrl_if;
   logic       start;
   logic       stop;
   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic       tx_done_tick;
   logic       st_wr_ps2;
   logic [7:0] st_tx_data;
   logic       st_disable_done_tick;
   logic       wr_ps2;
   logic [7:0] tx_data;
   logic       stream_enable;
   logic       stream_disable;
   logic       stream_rst;
   logic       ready;
   logic       busy;
   logic       error;

   modport master (
      output start, stop, rx_data, rx_done_tick, tx_done_tick,
             st_wr_ps2, st_tx_data, st_disable_done_tick,
      input  wr_ps2, tx_data, stream_enable, stream_disable, stream_rst,
             ready, busy, error
   );

   modport slave (
      input  start, stop, rx_data, rx_done_tick, tx_done_tick,
             st_wr_ps2, st_tx_data, st_disable_done_tick,
      output wr_ps2, tx_data, stream_enable, stream_disable, stream_rst,
             ready, busy, error
   );
endinterface

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse top-level sequencer: reset/self-test/sample-rate init with watchdog and retry,
// hands the link to the stream FSM, muxes the transmit port and performs an orderly stop.
module ps2_mouse_ctrl #(
   parameter logic [7:0] SAMPLE_RATE = 8'd100,
   parameter int         TIMEOUT_CYC = 2_000_000,
   parameter int         MAX_RETRY   = 3
) (
   input logic             clk,
   input logic             rst,
   ps2_mouse_ctrl_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

   typedef enum logic [3:0] {
      IDLE, SEND, WAIT_TX, WAIT_RX, FAIL, LAUNCH,
      STREAMING, HALT_RST, HALT_CMD, HALT_WAIT, ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    step_q, step_d, step_nx;
   logic [RW-1:0] retry_q, retry_d, retry_nx;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    txd_q, txd_d;
   logic          error_q, error_d;
   logic          expired;

   // Init step table: S0 reset, S1/S2 self-test reply, S3/S4 set sample rate.
   function automatic logic has_cmd(input logic [2:0] s);
      return (s == 3'd0) || (s == 3'd3) || (s == 3'd4);
   endfunction

   function automatic logic [7:0] cmd_byte(input logic [2:0] s);
      case (s)
         3'd0:    return 8'hFF;
         3'd3:    return 8'hF3;
         3'd4:    return SAMPLE_RATE;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] exp_byte(input logic [2:0] s);
      case (s)
         3'd1:    return 8'hAA;
         3'd2:    return 8'h00;
         default: return 8'hFA;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         retry_q <= '0;
         timer_q <= '0;
         txd_q   <= 8'h00;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         retry_q <= retry_d;
         timer_q <= timer_d;
         txd_q   <= txd_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      retry_d  = retry_q;
      txd_d    = txd_q;
      error_d  = error_q;
      timer_d  = '0;
      step_nx  = step_q + 3'd1;
      retry_nx = retry_q + RW'(1);
      expired  = (timer_q == T_LAST);
      unique case (state_q)
         IDLE, ERROR: begin
            if (bus.start) begin
               step_d  = '0;
               retry_d = '0;
               error_d = 1'b0;
               txd_d   = cmd_byte(3'd0);
               state_d = SEND;
            end
         end
         SEND: state_d = WAIT_TX;
         // A tick arriving in the expiry cycle takes priority over the timeout.
         WAIT_TX: begin
            if (bus.tx_done_tick)  state_d = WAIT_RX;
            else if (expired)      state_d = FAIL;
            else                   timer_d = timer_q + TW'(1);
         end
         WAIT_RX: begin
            if (bus.rx_done_tick) begin
               if (bus.rx_data != exp_byte(step_q)) begin
                  state_d = FAIL;
               end else if (step_q == 3'd4) begin
                  state_d = LAUNCH;
               end else begin
                  step_d = step_nx;
                  if (has_cmd(step_nx)) begin
                     txd_d   = cmd_byte(step_nx);
                     state_d = SEND;
                  end else begin
                     state_d = WAIT_RX;
                  end
               end
            end else if (expired) begin
               state_d = FAIL;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         FAIL: begin
            retry_d = retry_nx;
            if (retry_nx == R_MAX) begin
               error_d = 1'b1;
               state_d = ERROR;
            end else begin
               step_d  = '0;
               txd_d   = cmd_byte(3'd0);
               state_d = SEND;
            end
         end
         LAUNCH:    state_d = STREAMING;
         STREAMING: if (bus.stop) state_d = HALT_RST;
         HALT_RST:  state_d = HALT_CMD;
         HALT_CMD:  state_d = HALT_WAIT;
         HALT_WAIT: begin
            if (bus.st_disable_done_tick) begin
               state_d = IDLE;
            end else if (expired) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The stream FSM owns the transmit port only while streaming or draining its disable.
   always_comb begin
      bus.wr_ps2         = 1'b0;
      bus.tx_data        = txd_q;
      bus.stream_enable  = (state_q == LAUNCH);
      bus.stream_rst     = (state_q == HALT_RST);
      bus.stream_disable = (state_q == HALT_CMD);
      bus.ready          = (state_q == STREAMING);
      bus.busy           = !((state_q == IDLE) || (state_q == STREAMING) || (state_q == ERROR));
      bus.error          = error_q;
      case (state_q)
         SEND: bus.wr_ps2 = 1'b1;
         STREAMING, HALT_WAIT: begin
            bus.wr_ps2  = bus.st_wr_ps2;
            bus.tx_data = bus.st_tx_data;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Bench for ps2_mouse_ctrl: a procedural mouse replies to init commands; a table-level
// model of the init sequence predicts transmitted bytes, retries and final status.
module tb_ps2_mouse_ctrl;
   localparam int         TO = 16;
   localparam int         MR = 3;
   localparam logic [7:0] SR = 8'd100;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [7:0] wr_log[$];
   int   se_cnt = 0;

   ps2_mouse_ctrl_if bus();

   ps2_mouse_ctrl #(.SAMPLE_RATE(SR), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.wr_ps2) wr_log.push_back(bus.tx_data);
      if (bus.stream_enable) se_cnt <= se_cnt + 1;
   end

   // Reference init table
   function automatic bit step_has_cmd(input int s);
      return (s == 0) || (s == 3) || (s == 4);
   endfunction

   function automatic logic [7:0] step_cmd(input int s);
      case (s)
         0:       return 8'hFF;
         3:       return 8'hF3;
         4:       return SR;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] step_exp(input int s);
      case (s)
         1:       return 8'hAA;
         2:       return 8'h00;
         default: return 8'hFA;
      endcase
   endfunction

   function automatic logic [255:0] pack(input logic [7:0] q[$]);
      logic [255:0] v;
      v = '0;
      foreach (q[i]) v = {v[247:0], q[i]};
      v[255:248] = 8'(q.size());
      return v;
   endfunction

   function automatic logic [255:0] log_from(input int base);
      logic [7:0] q[$];
      for (int i = base; i < wr_log.size(); i++) q.push_back(wr_log[i]);
      return pack(q);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   // Mouse side of one init step: accept the command (if any), then reply.
   task automatic drive_step(input int s, input logic [7:0] reply, input int tx_dly, input int rx_dly);
      int n;
      if (step_has_cmd(s)) begin
         n = 0;
         while (!bus.wr_ps2 && n < 40) begin
            cyc();
            n++;
         end
         checks++;
         if (bus.wr_ps2 !== 1'b1) begin
            failures++;
            $display("FAIL wait_wr step=%0d got wr_ps2=%b want 1 within 40 cycles", s, bus.wr_ps2);
         end
         cyc();
         idle(tx_dly);
         bus.tx_done_tick = 1'b1;
         cyc();
         bus.tx_done_tick = 1'b0;
      end
      idle(rx_dly);
      bus.rx_data      = reply;
      bus.rx_done_tick = 1'b1;
      cyc();
      bus.rx_done_tick = 1'b0;
   endtask

   task automatic nominal_from(input int first);
      for (int s = first; s < 5; s++)
         drive_step(s, step_exp(s), $urandom_range(0, 4), $urandom_range(0, 4));
   endtask

   task automatic wait_settle();
      int n;
      n = 0;
      while (!bus.ready && !bus.error && n < 8) begin
         cyc();
         n++;
      end
   endtask

   task automatic go_idle();
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      idle(3);
      bus.st_disable_done_tick = 1'b1;
      cyc();
      bus.st_disable_done_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      checks++;
      if ({bus.wr_ps2, bus.tx_data, bus.stream_enable, bus.stream_disable, bus.stream_rst,
           bus.ready, bus.busy, bus.error} !== 15'h0) begin
         failures++;
         $display("FAIL reset_outputs got wr=%b tx=%h busy=%b err=%b want all 0",
                  bus.wr_ps2, bus.tx_data, bus.busy, bus.error);
      end
      @(negedge clk) rst = 1'b0;
      cyc();
   endtask

   task automatic test_nominal();
      int base, se0;
      logic [7:0] eq[$];
      base = wr_log.size();
      se0  = se_cnt;
      pulse_start();
      nominal_from(0);
      wait_settle();
      eq = '{8'hFF, 8'hF3, SR};
      checks++;
      if (log_from(base) !== pack(eq)) begin
         failures++;
         $display("FAIL nominal_writes got=%h want=%h", log_from(base), pack(eq));
      end
      checks++;
      if (se_cnt - se0 != 1) begin
         failures++;
         $display("FAIL nominal_enable got=%0d pulses want 1", se_cnt - se0);
      end
      checks++;
      if ({bus.ready, bus.busy, bus.error} !== 3'b100) begin
         failures++;
         $display("FAIL nominal_status got ready/busy/err=%b want 100", {bus.ready, bus.busy, bus.error});
      end
      go_idle();
   endtask

   task automatic test_mismatch_retry();
      int base;
      logic [7:0] eq[$];
      base = wr_log.size();
      pulse_start();
      drive_step(0, 8'hFE, 1, 2);
      nominal_from(0);
      wait_settle();
      eq = '{8'hFF, 8'hFF, 8'hF3, SR};
      checks++;
      if (log_from(base) !== pack(eq)) begin
         failures++;
         $display("FAIL retry_writes got=%h want=%h", log_from(base), pack(eq));
      end
      checks++;
      if ({bus.ready, bus.error} !== 2'b10) begin
         failures++;
         $display("FAIL retry_status got ready/err=%b want 10", {bus.ready, bus.error});
      end
      go_idle();
   endtask

   task automatic test_retry_exhaustion();
      int n, base;
      logic [7:0] eq[$];
      base = wr_log.size();
      pulse_start();
      for (int a = 0; a < MR; a++) begin
         n = 0;
         while (!bus.wr_ps2 && n < 40) begin
            cyc();
            n++;
         end
         cyc();
         bus.tx_done_tick = 1'b1;
         cyc();
         bus.tx_done_tick = 1'b0;
         n = 0;
         while (!bus.wr_ps2 && !bus.error && n < 40) begin
            cyc();
            n++;
         end
         checks++;
         if (n != TO + 1) begin
            failures++;
            $display("FAIL timeout_len attempt=%0d got=%0d cycles want %0d", a, n, TO + 1);
         end
      end
      eq = '{8'hFF, 8'hFF, 8'hFF};
      checks++;
      if (log_from(base) !== pack(eq)) begin
         failures++;
         $display("FAIL exhaust_writes got=%h want=%h", log_from(base), pack(eq));
      end
      checks++;
      if ({bus.error, bus.busy, bus.ready} !== 3'b100) begin
         failures++;
         $display("FAIL exhaust_status got err/busy/ready=%b want 100", {bus.error, bus.busy, bus.ready});
      end
      idle(2);
      pulse_start();
      checks++;
      if ({bus.error, bus.wr_ps2, bus.tx_data} !== {1'b0, 1'b1, 8'hFF}) begin
         failures++;
         $display("FAIL restart_after_error got err=%b wr=%b tx=%h want 0 1 ff",
                  bus.error, bus.wr_ps2, bus.tx_data);
      end
      nominal_from(0);
      wait_settle();
      checks++;
      if ({bus.ready, bus.error} !== 2'b10) begin
         failures++;
         $display("FAIL restart_status got ready/err=%b want 10", {bus.ready, bus.error});
      end
      go_idle();
   endtask

   task automatic test_passthrough_stop();
      logic [7:0] b;
      pulse_start();
      nominal_from(0);
      wait_settle();
      for (int i = 0; i < 4; i++) begin
         b = (i == 0) ? 8'hF4 : 8'($urandom);
         bus.st_tx_data = b;
         bus.st_wr_ps2  = 1'b1;
         #1;
         checks++;
         if ({bus.wr_ps2, bus.tx_data} !== {1'b1, b}) begin
            failures++;
            $display("FAIL stream_pass got wr=%b tx=%h want 1 %h", bus.wr_ps2, bus.tx_data, b);
         end
         cyc();
      end
      bus.st_wr_ps2 = 1'b0;
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      checks++;
      if ({bus.stream_rst, bus.stream_disable, bus.ready} !== 3'b100) begin
         failures++;
         $display("FAIL halt_rst got rst/dis/ready=%b want 100",
                  {bus.stream_rst, bus.stream_disable, bus.ready});
      end
      cyc();
      checks++;
      if ({bus.stream_rst, bus.stream_disable} !== 2'b01) begin
         failures++;
         $display("FAIL halt_cmd got rst/dis=%b want 01", {bus.stream_rst, bus.stream_disable});
      end
      cyc();
      b = 8'($urandom);
      bus.st_tx_data = b;
      bus.st_wr_ps2  = 1'b1;
      #1;
      checks++;
      if ({bus.wr_ps2, bus.tx_data, bus.busy} !== {1'b1, b, 1'b1}) begin
         failures++;
         $display("FAIL halt_pass got wr=%b tx=%h busy=%b want 1 %h 1", bus.wr_ps2, bus.tx_data, bus.busy, b);
      end
      cyc();
      bus.st_wr_ps2 = 1'b0;
      idle(2);
      bus.st_disable_done_tick = 1'b1;
      cyc();
      bus.st_disable_done_tick = 1'b0;
      checks++;
      if ({bus.ready, bus.busy, bus.error} !== 3'b000) begin
         failures++;
         $display("FAIL halt_done got ready/busy/err=%b want 000", {bus.ready, bus.busy, bus.error});
      end
      bus.st_wr_ps2  = 1'b1;
      bus.st_tx_data = 8'h5A;
      #1;
      checks++;
      if ({bus.wr_ps2, bus.tx_data} !== {1'b0, SR}) begin
         failures++;
         $display("FAIL idle_ignore_stream got wr=%b tx=%h want 0 %h", bus.wr_ps2, bus.tx_data, SR);
      end
      bus.st_wr_ps2 = 1'b0;
      cyc();
   endtask

   task automatic test_boundaries();
      int base;
      logic [7:0] eq[$];
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      idle(2);
      checks++;
      if ({bus.busy, bus.stream_rst, bus.stream_disable, bus.ready, bus.wr_ps2} !== 5'b0) begin
         failures++;
         $display("FAIL stop_in_idle got busy=%b srst=%b dis=%b", bus.busy, bus.stream_rst, bus.stream_disable);
      end
      base = wr_log.size();
      bus.stop  = 1'b1;
      bus.start = 1'b1;
      cyc();
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      checks++;
      if (bus.wr_ps2 !== 1'b1) begin
         failures++;
         $display("FAIL start_stop_idle got wr=%b want 1", bus.wr_ps2);
      end
      drive_step(0, 8'hFA, 2, 1);
      pulse_start();
      checks++;
      if ({bus.busy, bus.wr_ps2} !== 2'b10) begin
         failures++;
         $display("FAIL start_in_wait_rx got busy/wr=%b want 10", {bus.busy, bus.wr_ps2});
      end
      drive_step(1, 8'hAA, 0, 1);
      drive_step(2, 8'h00, 0, 2);
      drive_step(3, 8'hFA, TO - 1, TO - 1);
      drive_step(4, 8'hFA, 1, 1);
      wait_settle();
      eq = '{8'hFF, 8'hF3, SR};
      checks++;
      if (log_from(base) !== pack(eq)) begin
         failures++;
         $display("FAIL boundary_writes got=%h want=%h", log_from(base), pack(eq));
      end
      checks++;
      if ({bus.ready, bus.error} !== 2'b10) begin
         failures++;
         $display("FAIL tick_at_expiry got ready/err=%b want 10", {bus.ready, bus.error});
      end
      go_idle();
   endtask

   task automatic test_reset_mid_init();
      pulse_start();
      cyc();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.wr_ps2, bus.tx_data, bus.stream_enable, bus.stream_disable, bus.stream_rst,
           bus.ready, bus.busy, bus.error} !== 15'h0) begin
         failures++;
         $display("FAIL reset_mid_init got wr=%b tx=%h busy=%b err=%b want all 0",
                  bus.wr_ps2, bus.tx_data, bus.busy, bus.error);
      end
      idle(2);
      @(negedge clk) rst = 1'b0;
      cyc();
      pulse_start();
      checks++;
      if ({bus.wr_ps2, bus.tx_data} !== {1'b1, 8'hFF}) begin
         failures++;
         $display("FAIL restart_after_rst got wr=%b tx=%h want 1 ff", bus.wr_ps2, bus.tx_data);
      end
      nominal_from(0);
      wait_settle();
      go_idle();
   endtask

   task automatic test_random_retry();
      int k, f, base, se0;
      logic [7:0] bad;
      logic [7:0] eq[$];
      for (int t = 0; t < 8; t++) begin
         k    = $urandom_range(0, MR);
         eq   = {};
         base = wr_log.size();
         se0  = se_cnt;
         pulse_start();
         for (int a = 0; a < k; a++) begin
            f = $urandom_range(0, 4);
            for (int s = 0; s < f; s++) begin
               drive_step(s, step_exp(s), $urandom_range(0, 3), $urandom_range(0, 3));
               if (step_has_cmd(s)) eq.push_back(step_cmd(s));
            end
            if ($urandom_range(0, 3) == 0) bad = 8'hFE;
            else begin
               bad = 8'($urandom);
               while (bad == step_exp(f)) bad = 8'($urandom);
            end
            drive_step(f, bad, $urandom_range(0, 3), $urandom_range(0, 3));
            if (step_has_cmd(f)) eq.push_back(step_cmd(f));
         end
         if (k < MR) begin
            nominal_from(0);
            for (int s = 0; s < 5; s++) if (step_has_cmd(s)) eq.push_back(step_cmd(s));
         end
         wait_settle();
         checks++;
         if (log_from(base) !== pack(eq)) begin
            failures++;
            $display("FAIL rand_writes trial=%0d got=%h want=%h", t, log_from(base), pack(eq));
         end
         checks++;
         if ({bus.ready, bus.error, bus.busy} !== ((k < MR) ? 3'b100 : 3'b010)) begin
            failures++;
            $display("FAIL rand_status trial=%0d k=%0d got ready/err/busy=%b", t, k,
                     {bus.ready, bus.error, bus.busy});
         end
         checks++;
         if (se_cnt - se0 != ((k < MR) ? 1 : 0)) begin
            failures++;
            $display("FAIL rand_enable trial=%0d got=%0d pulses", t, se_cnt - se0);
         end
         if (bus.ready) go_idle();
      end
   endtask

   initial begin
      rst                      = 1'b1;
      bus.start                = 1'b0;
      bus.stop                 = 1'b0;
      bus.rx_data              = 8'h00;
      bus.rx_done_tick         = 1'b0;
      bus.tx_done_tick         = 1'b0;
      bus.st_wr_ps2            = 1'b0;
      bus.st_tx_data           = 8'h00;
      bus.st_disable_done_tick = 1'b0;
      test_reset();
      test_nominal();
      test_mismatch_retry();
      test_retry_exhaustion();
      test_passthrough_stop();
      test_boundaries();
      test_reset_mid_init();
      test_random_retry();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
